mips_muldiv_unit: RTL and testbench

//   Multi-cycle HI/LO multiply/divide unit for the MIPS core. Runs MULT/MULTU/DIV/DIVU
//   off the main ALU path and owns the architectural HI/LO registers, which MTHI/MTLO

---
 rtl/mips_muldiv_unit.sv | 212 +++++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Multi-cycle HI/LO multiply/divide unit. It runs MULT/MULTU/DIV/DIVU off the
//   main ALU path and owns the architectural HI/LO registers. MTHI/MTLO write
//   HI/LO directly. The pipeline stalls while busy_o is high.
//
//   state  | meaning
//   S_IDLE | waiting for start_i; MTHI/MTLO are handled here in a single edge
//   S_MUL  | multiply in flight; completes MUL_LATENCY edges after accept
//   S_DIV  | restoring divide; WIDTH iterations, then sign fix and write
//
// Ports
//   clk_i        rising-edge clock
//   reset_n_i    asynchronous active-low reset
//   start_i      request strobe, sampled only while idle
//   funct_i      24 MULT, 25 MULTU, 26 DIV, 27 DIVU, 17 MTHI, 19 MTLO
//   op1_i/op2_i  rs / rt operands
//   flush_i      cancels the in-flight operation; HI/LO keep their value
//   busy_o       multiply/divide in flight
//   done_o       one-cycle pulse after the edge that writes HI/LO
//   div_zero_o   last completed DIV/DIVU had a zero divisor
//   hi_o/lo_o    registered HI/LO
module mips_muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MTLO  = 6'd19;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, dz_q, dz_d;

    logic             accept;
    logic             in_signed;
    logic [WIDTH-1:0] op1_abs, op2_abs;
    logic [2*WIDTH-1:0] ma, mb, prod;
    logic [WIDTH:0]   rem_sh, diff;
    logic             q_neg, r_neg;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        // Sign-extend only for the signed variants; the low 2W bits of the
        // extended product are then correct for both MULT and MULTU.
        ma   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
        mb   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
        prod = ma * mb;

        in_signed = (funct_i == F_DIV);
        op1_abs   = (in_signed && op1_i[WIDTH-1]) ? -op1_i : op1_i;
        op2_abs   = (in_signed && op2_i[WIDTH-1]) ? -op2_i : op2_i;

        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        q_neg  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        r_neg  = sgn_q & a_q[WIDTH-1];

        accept = start_i && (state_q == S_IDLE) && !flush_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (funct_i)
                        F_MULT, F_MULTU: begin
                            state_d = S_MUL;
                            cnt_d   = '0;
                            a_d     = op1_i;
                            b_d     = op2_i;
                            sgn_d   = (funct_i == F_MULT);
                            dz_d    = 1'b0;
                        end
                        F_DIV, F_DIVU: begin
                            state_d = S_DIV;
                            cnt_d   = '0;
                            a_d     = op1_i;
                            b_d     = op2_i;
                            sgn_d   = in_signed;
                            rem_d   = '0;
                            quo_d   = op1_abs;
                            dvs_d   = op2_abs;
                            dz_d    = 1'b0;
                        end
                        F_MTHI: begin
                            hi_d = op1_i;
                            dz_d = 1'b0;
                        end
                        F_MTLO: begin
                            lo_d = op1_i;
                            dz_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    state_d = S_IDLE;
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                    lo_d    = prod[WIDTH-1:0];
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DIV: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == DIV_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (b_q == '0) begin
                        lo_d = '1;
                        hi_d = a_q;
                        dz_d = 1'b1;
                    end else begin
                        // MIN/-1 falls out naturally: |MIN| negated is MIN again.
                        lo_d = q_neg ? -quo_q : quo_q;
                        hi_d = r_neg ? -rem_q : rem_q;
                    end
                end else begin
                    // Restoring step: shift in next dividend bit, subtract if it fits.
                    cnt_d = cnt_q + CW'(1);
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
module tb_mips_muldiv_unit;
    localparam int W = 32;
    localparam int L = 2;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         start_i;
    logic [5:0]   funct_i;
    logic [W-1:0] op1_i, op2_i;
    logic         flush_i;
    logic         busy_o, done_o, div_zero_o;
    logic [W-1:0] hi_o, lo_o;

    mips_muldiv_unit #(.WIDTH(W), .MUL_LATENCY(L)) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .start_i    (start_i),
        .funct_i    (funct_i),
        .op1_i      (op1_i),
        .op2_i      (op2_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sb;
        logic [63:0] p;
        int          q, r;
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        e.lat = 0;
        case (f)
            6'd24: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.lat = L;
            end
            6'd25: begin
                p  = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.lat = L;
            end
            6'd26, 6'd27: begin
                e.lat = W + 1;
                if (b == 0) begin
                    e.lo = '1;
                    e.hi = a;
                    e.dz = 1'b1;
                end else if (f == 6'd26 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = '0;
                end else if (f == 6'd26) begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    e.lo = q;
                    e.hi = r;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Drive one request; returns #1 after the accept edge with operands scrambled.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        funct_i = f;
        op1_i   = a;
        op2_i   = b;
        start_i = 1'b1;
        if (f >= 6'd24 && f <= 6'd27) sbq.push_back(model(f, a, b));
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        funct_i = 6'($urandom);
        op1_i   = $urandom;
        op2_i   = $urandom;
        if (f >= 6'd24 && f <= 6'd27) check("busy_after_accept", busy_o, 1);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   k;
        bit   got;
        got = 1'b0;
        k   = 0;
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sbq.pop_front();
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o) begin
                got = 1'b1;
                k   = i;
                break;
            end
        end
        check({tag, "_done_seen"}, got, 1);
        if (got) begin
            check({tag, "_latency"}, k, e.lat);
            check({tag, "_hi"}, hi_o, e.hi);
            check({tag, "_lo"}, lo_o, e.lo);
            check({tag, "_div_zero"}, div_zero_o, e.dz);
            check({tag, "_busy_low"}, busy_o, 0);
        end
    endtask

    initial begin
        int nd;
        logic [5:0] rf;
        logic [W-1:0] ra, rb;

        reset_n_i = 1'b0;
        start_i   = 1'b0;
        funct_i   = '0;
        op1_i     = '0;
        op2_i     = '0;
        flush_i   = 1'b0;
        #1;
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_dz", div_zero_o, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        issue(6'd24, -32'sd3, 32'd7);
        wait_done("mult_neg");
        issue(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max");
        issue(6'd26, -32'sd7, 32'd2);
        wait_done("div_neg");
        issue(6'd27, 32'd100, 32'd0);
        wait_done("divu_zero");
        issue(6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf");
        issue(6'd26, 32'd7, -32'sd2);
        wait_done("div_neg_divisor");

        issue(6'd17, 32'h0000_1234, 32'd0);
        check("mthi_hi", hi_o, 32'h0000_1234);
        check("mthi_busy", busy_o, 0);
        check("mthi_done", done_o, 0);
        issue(6'd19, 32'hCAFE_0001, 32'd0);
        check("mtlo_lo", lo_o, 32'hCAFE_0001);
        check("mtlo_hi_kept", hi_o, 32'h0000_1234);

        // DIV then flush at cycle 10; an MTHI attempted while busy must be ignored.
        issue(6'd26, 32'd50, 32'd7);
        void'(sbq.pop_front());
        @(posedge clk_i);
        #1;
        funct_i = 6'd17;
        op1_i   = 32'hDEAD_BEEF;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (7) @(posedge clk_i);
        #1;
        check("flush_busy_before", busy_o, 1);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_busy", busy_o, 0);
        check("flush_done", done_o, 0);
        check("flush_hi_kept", hi_o, 32'h0000_1234);
        check("flush_lo_kept", lo_o, 32'hCAFE_0001);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o) nd++;
        end
        check("flush_no_late_done", nd, 0);

        for (int i = 0; i < 8; i++) begin
            rf = 6'($urandom_range(24, 27));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ((i[0]) ? 32'($urandom_range(1, 1000)) : $urandom);
            issue(rf, ra, rb);
            wait_done("rand");
        end

        // Reset asserted at cycle 5 of a DIV aborts immediately.
        issue(6'd26, 32'd1000, 32'd3);
        void'(sbq.pop_front());
        repeat (4) @(posedge clk_i);
        #1;
        check("pre_rst_busy", busy_o, 1);
        reset_n_i = 1'b0;
        #1;
        check("mid_rst_hi", hi_o, 0);
        check("mid_rst_lo", lo_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", done_o, 0);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        issue(6'd24, 32'd123456, -32'sd789);
        wait_done("mult_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
